// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arb_pkg
//  Description : Shared definitions for the arbitrated adder block.
//                - Default operand width and requester count
//                - Output-register occupancy state encoding (EMPTY / FULL)
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    // Default operand / sum width in bits.
    localparam int c_DEF_WIDTH = 32;

    // Default number of requesters sharing the adder (legal range 2..8).
    localparam int c_DEF_NREQ = 3;

    // Occupancy of the single result register.
    typedef enum logic [0:0] {
        EMPTY = 1'b0,   // no result held, rsp_valid low
        FULL  = 1'b1    // a result is waiting for the consumer
    } rsp_state_t;

endpackage : adder_arb_pkg
`default_nettype wire

// File: rtl/param_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : param_cla_adder
//  Description : Parameterised carry-lookahead adder, purely combinational.
//                Operands are split into 4-bit groups. Each group produces a
//                group generate/propagate pair; group carries are resolved
//                from those, and the carries inside each group are expanded
//                from the group carry-in.
//  Ports       : i_a, i_b  [WIDTH-1:0]  operands
//                i_cin                  carry-in
//                o_sum     [WIDTH-1:0]  (i_a + i_b + i_cin) mod 2^WIDTH
//                o_cout                 carry out of bit WIDTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module param_cla_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    // Operands are zero-padded up to a whole number of 4-bit groups.
    localparam int c_NBLK = (WIDTH + 3) / 4;
    localparam int c_PW   = c_NBLK * 4;

    logic [c_PW-1:0]   w_pa;
    logic [c_PW-1:0]   w_pb;
    logic [c_PW-1:0]   w_g;      // bit generate
    logic [c_PW-1:0]   w_p;      // bit propagate
    logic [c_PW-1:0]   w_c;      // carry into each bit
    logic [c_PW-1:0]   w_s;
    logic [c_NBLK-1:0] w_bg;     // group generate
    logic [c_NBLK-1:0] w_bp;     // group propagate
    logic [c_NBLK:0]   w_bc;     // carry into each group (plus final carry)

    always_comb begin
        w_pa              = '0;
        w_pb              = '0;
        w_pa[WIDTH-1:0]   = i_a;
        w_pb[WIDTH-1:0]   = i_b;
    end

    assign w_g = w_pa & w_pb;
    assign w_p = w_pa ^ w_pb;

    // Per-group lookahead: group G/P and the three internal carries.
    generate
        for (genvar k = 0; k < c_NBLK; k++) begin : g_grp
            localparam int c_B = 4 * k;

            assign w_bg[k] = w_g[c_B+3]
                           | (w_p[c_B+3] & w_g[c_B+2])
                           | (w_p[c_B+3] & w_p[c_B+2] & w_g[c_B+1])
                           | (w_p[c_B+3] & w_p[c_B+2] & w_p[c_B+1] & w_g[c_B]);
            assign w_bp[k] = &w_p[c_B +: 4];

            assign w_c[c_B]   = w_bc[k];
            assign w_c[c_B+1] = w_g[c_B]
                              | (w_p[c_B] & w_bc[k]);
            assign w_c[c_B+2] = w_g[c_B+1]
                              | (w_p[c_B+1] & w_g[c_B])
                              | (w_p[c_B+1] & w_p[c_B] & w_bc[k]);
            assign w_c[c_B+3] = w_g[c_B+2]
                              | (w_p[c_B+2] & w_g[c_B+1])
                              | (w_p[c_B+2] & w_p[c_B+1] & w_g[c_B])
                              | (w_p[c_B+2] & w_p[c_B+1] & w_p[c_B] & w_bc[k]);
        end
    endgenerate

    // Group-level carry resolution from the group G/P pairs.
    always_comb begin
        w_bc[0] = i_cin;
        for (int k = 0; k < c_NBLK; k++) begin
            w_bc[k+1] = w_bg[k] | (w_bp[k] & w_bc[k]);
        end
    end

    assign w_s   = w_p ^ w_c;
    assign o_sum = w_s[WIDTH-1:0];

    // With no padding the carry out is the last group carry; otherwise it is
    // the carry into the first padding bit.
    generate
        if (WIDTH == c_PW) begin : g_cout_full
            assign o_cout = w_bc[c_NBLK];
        end else begin : g_cout_pad
            assign o_cout = w_c[WIDTH];
        end
    endgenerate

endmodule : param_cla_adder
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_arbiter
//  Description : One shared adder serving NREQ requesters. A round-robin
//                arbiter picks one requester per cycle; its operands are
//                muxed into the adder and the result is captured in a single
//                output register with valid/ready handshake. A pop and a new
//                accept in the same cycle keep the register full, giving one
//                operation per cycle with one cycle of latency.
//  Ports       : clk            clock, rising edge
//                rst_n          asynchronous active-low reset
//                i_req_valid    [NREQ]          per-requester request
//                i_req_a/_b     [NREQ][WIDTH]   per-requester operands
//                i_req_cin      [NREQ]          per-requester carry-in
//                o_req_ready    [NREQ]          one-hot accept (or zero)
//                o_rsp_valid                    result register full
//                o_rsp_id       [IDW]           owner of the result
//                o_rsp_sum      [WIDTH]         registered sum
//                o_rsp_cout                     registered carry-out
//                i_rsp_ready                    consumer takes the result
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int NREQ  = c_DEF_NREQ,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            i_req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0] i_req_a,
    input  logic [NREQ-1:0][WIDTH-1:0] i_req_b,
    input  logic [NREQ-1:0]            i_req_cin,
    output logic [NREQ-1:0]            o_req_ready,
    output logic                       o_rsp_valid,
    output logic [IDW-1:0]             o_rsp_id,
    output logic [WIDTH-1:0]           o_rsp_sum,
    output logic                       o_rsp_cout,
    input  logic                       i_rsp_ready
);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    rsp_state_t        r_state;
    rsp_state_t        w_state_nxt;

    logic [IDW-1:0]    r_ptr;        // round-robin search start
    logic [IDW-1:0]    r_id;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic [IDW-1:0]    w_gnt_idx;    // winning requester (meaningful if any valid)
    logic [IDW-1:0]    w_ptr_nxt;
    logic              w_can_accept;
    logic              w_accept;

    logic [WIDTH-1:0]  w_mux_a;
    logic [WIDTH-1:0]  w_mux_b;
    logic              w_mux_cin;
    logic [WIDTH-1:0]  w_add_sum;
    logic              w_add_cout;

    // ------------------------------------------------------------------------
    // Round-robin pick: first asserted valid at or after the pointer,
    // wrapping from NREQ-1 back to 0. Returns 0 when nothing is valid; the
    // caller qualifies the result with |valid.
    // ------------------------------------------------------------------------
    function automatic logic [IDW-1:0] f_rr_pick(
        input logic [NREQ-1:0] valid,
        input logic [IDW-1:0]  ptr
    );
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
        return pick;
    endfunction

    assign w_gnt_idx = f_rr_pick(i_req_valid, r_ptr);

    // Pointer moves to the requester just after the winner so it has the
    // lowest priority next time.
    assign w_ptr_nxt = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : (w_gnt_idx + IDW'(1));

    // ------------------------------------------------------------------------
    // Operand mux and the single shared adder. Operands only reach registers,
    // never an output port directly.
    // ------------------------------------------------------------------------
    assign w_mux_a   = i_req_a[w_gnt_idx];
    assign w_mux_b   = i_req_b[w_gnt_idx];
    assign w_mux_cin = i_req_cin[w_gnt_idx];

    param_cla_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a    (w_mux_a),
        .i_b    (w_mux_b),
        .i_cin  (w_mux_cin),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    // ------------------------------------------------------------------------
    // Output-register FSM: next state and request handshake
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_can_accept = 1'b0;
        w_accept     = 1'b0;
        o_req_ready  = '0;

        // A new result may be written when the register is empty or is being
        // drained in this same cycle.
        w_can_accept = (r_state == EMPTY) || i_rsp_ready;
        w_accept     = w_can_accept && (|i_req_valid);

        if (w_accept) begin
            o_req_ready = NREQ'(1) << w_gnt_idx;
            w_state_nxt = FULL;
        end else begin
            case (r_state)
                FULL:    if (i_rsp_ready) w_state_nxt = EMPTY;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Result register and arbitration pointer. Both only change on an
    // accepted request; a plain pop leaves the last result visible.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_accept) begin
            r_sum  <= w_add_sum;
            r_cout <= w_add_cout;
            r_id   <= w_gnt_idx;
            r_ptr  <= w_ptr_nxt;
        end
    end

    assign o_rsp_valid = (r_state == FULL);
    assign o_rsp_id    = r_id;
    assign o_rsp_sum   = r_sum;
    assign o_rsp_cout  = r_cout;

endmodule : adder_arbiter
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_arbiter
//  Description : Self-checking bench for adder_arbiter. Stimulus tasks keep a
//                behavioural model (pending requests, round-robin pointer,
//                result-register occupancy) and push each expected result into
//                a queue; an independent monitor compares the DUT response
//                against the queue head every cycle it is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;

    localparam int WIDTH = 32;
    localparam int NREQ  = 3;
    localparam int IDW   = 2;

    logic                       clk;
    logic                       rst_n;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][WIDTH-1:0] req_a;
    logic [NREQ-1:0][WIDTH-1:0] req_b;
    logic [NREQ-1:0]            req_cin;
    logic [NREQ-1:0]            req_ready;
    logic                       rsp_valid;
    logic [IDW-1:0]             rsp_id;
    logic [WIDTH-1:0]           rsp_sum;
    logic                       rsp_cout;
    logic                       rsp_ready;

    adder_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_cin   (req_cin),
        .o_req_ready (req_ready),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_sum   (rsp_sum),
        .o_rsp_cout  (rsp_cout),
        .i_rsp_ready (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } rsp_t;

    rsp_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;

    // Reference model state
    int               m_ptr;
    bit               m_full;
    bit               exp_vld;      // expected rsp_valid during the current cycle
    bit               pend [NREQ];
    logic [WIDTH-1:0] pa   [NREQ];
    logic [WIDTH-1:0] pb   [NREQ];
    logic             pc   [NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic post(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        pc[i]   = c;
    endtask

    function automatic bit any_pend();
        bit r;
        r = 1'b0;
        for (int i = 0; i < NREQ; i++) r = r | pend[i];
        return r;
    endfunction

    // Called 1 time unit after a rising edge; returns 1 unit after the next.
    task automatic step(input bit rready, input bit rearm);
        int               chosen;
        int               idx;
        logic [NREQ-1:0]  exp_rdy;
        logic [WIDTH:0]   s;
        rsp_t             e;
        rsp_ready = rready;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pend[i];
            if (pend[i]) begin
                req_a[i]   = pa[i];
                req_b[i]   = pb[i];
                req_cin[i] = pc[i];
            end else begin
                req_a[i]   = rand_word();
                req_b[i]   = rand_word();
                req_cin[i] = 1'($urandom);
            end
        end
        #1;
        exp_vld = m_full;
        chosen  = -1;
        if (!m_full || rready) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (chosen < 0 && pend[idx]) chosen = idx;
            end
        end
        exp_rdy = '0;
        if (chosen >= 0) exp_rdy[chosen] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (chosen >= 0) begin
            s      = {1'b0, pa[chosen]} + {1'b0, pb[chosen]} + (WIDTH+1)'(pc[chosen]);
            e.id   = IDW'(chosen);
            e.sum  = s[WIDTH-1:0];
            e.cout = s[WIDTH];
            exp_q.push_back(e);
            m_ptr  = (chosen + 1) % NREQ;
            m_full = 1'b1;
            if (rearm) post(chosen, rand_word(), rand_word(), 1'($urandom));
            else       pend[chosen] = 1'b0;
        end else if (rready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_flush();
        req_valid = '0;
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        exp_q.delete();
        m_full  = 1'b0;
        m_ptr   = 0;
        exp_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        model_flush();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares the presented response with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
                if (exp_vld) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard: got response id=%0d but queue is empty", rsp_id);
                    end else begin
                        check("rsp_id",   64'(rsp_id),   64'(exp_q[0].id));
                        check("rsp_sum",  64'(rsp_sum),  64'(exp_q[0].sum));
                        check("rsp_cout", 64'(rsp_cout), 64'(exp_q[0].cout));
                        if (rsp_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b0;
        model_flush();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        check("rst_valid", 64'(rsp_valid), 64'd0);
        check("rst_id",    64'(rsp_id),    64'd0);
        check("rst_sum",   64'(rsp_sum),   64'd0);
        check("rst_cout",  64'(rsp_cout),  64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;

        // Single operation, one-cycle latency
        post(0, 32'd5, 32'd3, 1'b0);
        step(1'b1, 1'b0);
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_sum",   64'(rsp_sum),   64'h8);
        check("single_cout",  64'(rsp_cout),  64'd0);
        check("single_id",    64'(rsp_id),    64'd0);

        // Overflow wrap and carry-in
        post(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        step(1'b1, 1'b0);
        check("ovf_sum",  64'(rsp_sum),  64'h0);
        check("ovf_cout", 64'(rsp_cout), 64'd1);
        check("ovf_id",   64'(rsp_id),   64'd1);
        post(1, 32'h1234_5678, 32'h8765_4321, 1'b1);
        step(1'b1, 1'b0);
        check("cin_sum",  64'(rsp_sum),  64'h9999_999A);
        check("cin_cout", 64'(rsp_cout), 64'd0);

        // Round-robin with all requesters continuously valid
        do_reset();
        for (int i = 0; i < NREQ; i++) post(i, rand_word(), rand_word(), 1'($urandom));
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b1);
            check("rr_id",    64'(rsp_id),    64'(k % 3));
            check("rr_valid", 64'(rsp_valid), 64'd1);
        end

        // Backpressure: result held, req2 waits, then accepted on release
        do_reset();
        post(0, 32'h0000_00AA, 32'h0000_0055, 1'b0);
        step(1'b1, 1'b0);
        post(2, 32'h0000_0010, 32'h0000_0020, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_sum",   64'(rsp_sum),   64'hFF);
            check("bp_id",    64'(rsp_id),    64'd0);
            check("bp_valid", 64'(rsp_valid), 64'd1);
        end
        step(1'b1, 1'b0);
        check("bp_rel_id",  64'(rsp_id),  64'd2);
        check("bp_rel_sum", 64'(rsp_sum), 64'h31);

        // Asynchronous reset while FULL
        do_reset();
        post(1, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        step(1'b0, 1'b0);
        check("mid_id",  64'(rsp_id),  64'd1);
        check("mid_sum", 64'(rsp_sum), 64'hFF);
        #2;
        rst_n = 1'b0;
        model_flush();
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_sum",   64'(rsp_sum),   64'd0);
        check("mid_rst_id",    64'(rsp_id),    64'd0);
        check("mid_rst_cout",  64'(rsp_cout),  64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
        check("mid_no_stale", 64'(rsp_valid), 64'd0);

        // Skip over idle requesters; pointer wraps to 0 after granting 2
        do_reset();
        post(2, rand_word(), rand_word(), 1'b0);
        step(1'b1, 1'b0);
        check("skip_id2", 64'(rsp_id), 64'd2);
        post(0, rand_word(), rand_word(), 1'b1);
        post(1, rand_word(), rand_word(), 1'b0);
        step(1'b1, 1'b0);
        check("skip_id0", 64'(rsp_id), 64'd0);
        step(1'b1, 1'b0);
        check("skip_id1", 64'(rsp_id), 64'd1);

        // Randomised traffic with random backpressure
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    post(i, rand_word(), rand_word(), 1'($urandom));
            end
            step($urandom_range(0, 3) != 0, 1'b0);
        end

        // Drain outstanding requests and the held result
        for (int k = 0; k < 20 && (m_full || any_pend()); k++) step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("drain_queue", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_adder_arbiter
`default_nettype wire

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand/sum width in bits.
REQ-002 Parameter NREQ, default 3, number of requesters (2..8).
REQ-003 Parameter IDW, default $clog2(NREQ), requester-ID width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NREQ  per-requester operation request.
REQ-007 req_a  input  NREQ x WIDTH  operand A per requester.
REQ-008 req_b  input  NREQ x WIDTH  operand B per requester.
REQ-009 req_cin  input  NREQ  carry-in per requester.
REQ-010 req_ready  output  NREQ  request accepted this cycle (one-hot or zero).
REQ-011 rsp_valid  output  1  result register holds a valid result.
REQ-012 rsp_id  output  IDW  index of requester owning the result.
REQ-013 rsp_sum  output  WIDTH  registered a+b+cin, modulo 2^WIDTH.
REQ-014 rsp_cout  output  1  registered carry-out.
REQ-015 rsp_ready  input  1  consumer accepts result this cycle.

Function
REQ-016 Block SHALL share one adder among NREQ requesters; transfer occurs when req_valid[i] && req_ready[i] (request) or rsp_valid && rsp_ready (response).
REQ-017 Output register SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-018 can_accept = EMPTY || (FULL && rsp_ready); req_ready SHALL be zero when can_accept is 0.
REQ-019 When can_accept, grant SHALL go to first asserted req_valid at or after round-robin pointer ptr, wrapping NREQ-1 -> 0; req_ready is one-hot on that index.
REQ-020 On accepted request i: rsp_sum/rsp_cout SHALL load adder result of req_a[i], req_b[i], req_cin[i]; rsp_id <= i; state FULL; ptr <= (i+1) mod NREQ.
REQ-021 Latency SHALL be exactly one cycle: accepted in cycle N -> rsp_valid high in cycle N+1.
REQ-022 Simultaneous response pop and new accept SHALL remain FULL with new result (throughput 1 op/cycle, no bubble).
REQ-023 Pop with no new accept SHALL go FULL -> EMPTY; rsp_sum/rsp_cout/rsp_id SHALL hold last values.
REQ-024 While FULL and rsp_ready=0, rsp_* SHALL remain stable and ptr SHALL not change.
REQ-025 ptr SHALL not advance when no request is accepted.
REQ-026 Requester SHALL hold req_valid and operands stable until accepted; block need not tolerate violation.
REQ-027 req_ready SHALL depend combinationally on req_valid, ptr, state and rsp_ready; no combinational path from operands to any output.
REQ-028 Overflow SHALL wrap: sum truncated to WIDTH, cout = bit WIDTH.

Reset
REQ-029 rst_n low SHALL immediately force: state EMPTY, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, ptr=0.
REQ-030 Reset mid-operation SHALL discard any held result; no response for it after deassertion.
REQ-031 First grant after reset SHALL favor requester 0.

Structure
REQ-032 Shared package adder_arb_pkg SHALL hold default WIDTH/NREQ constants and the state enum (EMPTY, FULL).
REQ-033 Exactly one instance of existing sub-module param_cla_adder #(WIDTH) SHALL compute the sum from muxed granted operands.
REQ-034 Round-robin grant logic SHALL be a function or block inside adder_arbiter, not a separate module.

Verification
REQ-035 Single: req0 a=5 b=3 cin=0, rsp_ready=1 -> next cycle rsp_valid=1, sum=00000008, cout=0, id=0.
REQ-036 Overflow: req1 a=FFFFFFFF b=00000001 cin=0 -> sum=00000000, cout=1, id=1; a=12345678 b=87654321 cin=1 -> sum=9999999A, cout=0.
REQ-037 Round-robin: all three valid continuously, rsp_ready=1 after reset -> ids 0,1,2,0,1,2 on consecutive cycles, rsp_valid never drops.
REQ-038 Backpressure: FULL with rsp_ready=0 for 4 cycles, req2 valid -> req_ready=0, rsp_* stable; rsp_ready=1 -> req2 accepted same cycle, result next cycle.
REQ-039 Reset mid-op: rst_n low while FULL (id=1, sum=000000FF) -> rsp_valid=0 and all outputs 0 immediately, no stale response after release.
REQ-040 Skip: only req2 valid after reset -> granted id=2, ptr=0; then req0 and req1 both valid -> req0 granted first.
